// File: rtl/rv32_pkg.sv
// Shared RV32I encodings: opcodes, sequencer states and mux selects used by the
// controller, immediate generator and ALU decode.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMMU = 2'd3;

endpackage

// File: rtl/op_class_dec.sv
// Opcode classifier: turns a 7-bit RV32I opcode into the instruction-class flags
// the sequencer branches on.
module op_class_dec
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       is_lui,
  output logic       is_alu,
  output logic       legal
);

  // AUIPC writes back through the ALU path, so it is grouped with OP/OP-IMM.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_lui    = 1'b0;
    is_alu    = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OPC_LOAD:                     is_load   = 1'b1;
      OPC_STORE:                    is_store  = 1'b1;
      OPC_BRANCH:                   is_branch = 1'b1;
      OPC_JAL:                      is_jal    = 1'b1;
      OPC_JALR:                     is_jalr   = 1'b1;
      OPC_LUI:                      is_lui    = 1'b1;
      OPC_OP, OPC_OPIMM, OPC_AUIPC: is_alu    = 1'b1;
      default:                      legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback and counts retired instructions.
module multicycle_ctrl
  import rv32_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        imm_en,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t      r_state;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [31:0] r_instret;

  logic w_isLoad, w_isStore, w_isBranch, w_isJal, w_isJalr, w_isLui, w_isAlu, w_legal;
  logic w_retire;
  logic w_unused;

  op_class_dec u_opClassDec (
    .opcode    (r_opcode),
    .is_load   (w_isLoad),
    .is_store  (w_isStore),
    .is_branch (w_isBranch),
    .is_jal    (w_isJal),
    .is_jalr   (w_isJalr),
    .is_lui    (w_isLui),
    .is_alu    (w_isAlu),
    .legal     (w_legal)
  );

  // Operand and immediate fields are consumed by the datapath straight from IR.
  assign w_unused = ^{instr[31:15], r_funct3};

  // Every retired instruction ends with exactly one PC write.
  assign w_retire = pc_we;

  // Control strobes decode the current state and latched fields; ir_load is
  // held off during reset so an aborted cycle cannot look like a fetch.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    imm_en   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_PLUS4;
    reg_we   = 1'b0;
    wb_sel   = WB_SEL_ALU;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready & ~reset;
      end
      ST_DECODE: imm_en = 1'b1;
      ST_EXECUTE: begin
        if (w_isBranch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_isStore;
        pc_we    = w_isStore & dmem_ready;
      end
      ST_WB: begin
        reg_we = (r_rd != 5'd0);
        pc_we  = 1'b1;
        if (w_isLoad)               wb_sel = WB_SEL_LOAD;
        else if (w_isJal | w_isJalr) wb_sel = WB_SEL_PC4;
        else if (w_isLui)           wb_sel = WB_SEL_IMMU;
        if (w_isJal)                pc_sel = PC_SEL_BRANCH;
        else if (w_isJalr)          pc_sel = PC_SEL_JALR;
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, latched instruction fields and retire counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_opcode  <= 7'd0;
      r_funct3  <= 3'd0;
      r_rd      <= 5'd0;
      r_instret <= 32'd0;
    end else begin
      if (w_retire) r_instret <= r_instret + 32'd1;
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_opcode <= instr[6:0];
            r_rd     <= instr[11:7];
            r_funct3 <= instr[14:12];
            r_state  <= ST_DECODE;
          end
        end
        ST_DECODE: r_state <= w_legal ? ST_EXECUTE : ST_TRAP;
        ST_EXECUTE: begin
          if (w_isLoad | w_isStore)                      r_state <= ST_MEM;
          else if (w_isBranch)                           r_state <= ST_FETCH;
          else if (w_isAlu | w_isJal | w_isJalr | w_isLui) r_state <= ST_WB;
          else                                           r_state <= ST_TRAP;
        end
        ST_MEM: begin
          if (dmem_ready) r_state <= w_isLoad ? ST_WB : ST_FETCH;
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: walks ALU, load, store,
// branch, jump, illegal-opcode and mid-instruction reset sequences.
module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [31:0] instr;
  logic        branch_taken;
  logic        dmem_ready;
  logic        imem_req, ir_load, imm_en, pc_we, reg_we, dmem_req, dmem_we, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .instr        (instr),
    .branch_taken (branch_taken),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .imm_en       (imm_en),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .illegal      (illegal),
    .state        (state),
    .instret      (instret)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic imemRdy, input logic [31:0] word,
                               input logic dmemRdy, input logic brTaken);
    imem_ready   = imemRdy;
    instr        = word;
    dmem_ready   = dmemRdy;
    branch_taken = brTaken;
  endtask

  // Compares the whole control-output bundle against hand-computed values.
  task automatic expectCycle(input string tag, input logic [2:0] st,
                             input logic imemReq, input logic irLoad, input logic immEn,
                             input logic pcWe, input logic [1:0] pcSel, input logic regWe,
                             input logic [1:0] wbSel, input logic dmemReq,
                             input logic dmemWe, input logic ill);
    logic [14:0] obs, exp;
    obs = {state, imem_req, ir_load, imm_en, pc_we, pc_sel, reg_we, wb_sel,
           dmem_req, dmem_we, illegal};
    exp = {st, imemReq, irLoad, immEn, pcWe, pcSel, regWe, wbSel, dmemReq, dmemWe, ill};
    checkOutput(tag, {17'd0, obs}, {17'd0, exp});
  endtask

  task automatic nextCycle();
    @(negedge clock);
  endtask

  // Starts in a FETCH cycle; ends in the DECODE cycle. The instruction bus is
  // scrambled after the latch to show the fields were captured.
  task automatic fetchDecode(input string tag, input logic [31:0] word);
    applyStimulus(1'b1, word, 1'b0, 1'b0);
    #1 expectCycle({tag, "_fetch"}, 3'd0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1 expectCycle({tag, "_decode"}, 3'd1, 0, 0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic retireCheck(input string tag, input logic [31:0] expInstret);
    nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1 expectCycle({tag, "_next"}, 3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    checkOutput({tag, "_instret"}, instret, expInstret);
  endtask

  task automatic execIdle(input string tag);
    nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1 expectCycle({tag, "_exec"}, 3'd2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic wbCycle(input string tag, input logic regWe, input logic [1:0] wbSel,
                         input logic [1:0] pcSel);
    nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1 expectCycle({tag, "_wb"}, 3'd4, 0, 0, 0, 1, pcSel, regWe, wbSel, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    reset = 1'b0;
    #1 expectCycle("reset", 3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    checkOutput("reset_instret", instret, 32'd0);

    // ADDI x1,x0,5
    fetchDecode("addi", 32'h0050_0093);
    execIdle("addi");
    wbCycle("addi", 1'b1, 2'd0, 2'd0);
    checkOutput("addi_instret_pre", instret, 32'd0);
    retireCheck("addi", 32'd1);

    // Two fetch wait cycles, then LW x2,0(x1) with three data wait cycles
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0000_A103, 1'b0, 1'b0);
      #1 expectCycle("fetch_wait", 3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      nextCycle();
    end
    fetchDecode("lw", 32'h0000_A103);
    execIdle("lw");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      #1 expectCycle("lw_memwait", 3'd3, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
    end
    nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    #1 expectCycle("lw_memdone", 3'd3, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
    wbCycle("lw", 1'b1, 2'd1, 2'd0);
    retireCheck("lw", 32'd2);

    // BEQ x0,x0,8 taken then not taken (rd field bits are nonzero imm bits)
    for (int t = 1; t >= 0; t--) begin
      fetchDecode("beq", 32'h0000_0463);
      nextCycle();
      applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, t[0]);
      #1 expectCycle(t[0] ? "beq_taken" : "beq_nottaken", 3'd2, 0, 0, 0, 1,
                     t[0] ? 2'd1 : 2'd0, 0, 2'd0, 0, 0, 0);
      retireCheck("beq", t[0] ? 32'd3 : 32'd4);
    end

    // JALR x0,0(x1): no register write, pc_sel selects the ALU target
    fetchDecode("jalr", 32'h0000_8067);
    execIdle("jalr");
    wbCycle("jalr", 1'b0, 2'd2, 2'd2);
    retireCheck("jalr", 32'd5);

    // ADDI x0,x0,0 (nop): rd=0 suppresses reg_we
    fetchDecode("nop", 32'h0000_0013);
    execIdle("nop");
    wbCycle("nop", 1'b0, 2'd0, 2'd0);
    retireCheck("nop", 32'd6);

    // JAL x1,8
    fetchDecode("jal", 32'h0080_00EF);
    execIdle("jal");
    wbCycle("jal", 1'b1, 2'd2, 2'd1);
    retireCheck("jal", 32'd7);

    // LUI x5,0x12345
    fetchDecode("lui", 32'h1234_52B7);
    execIdle("lui");
    wbCycle("lui", 1'b1, 2'd3, 2'd0);
    retireCheck("lui", 32'd8);

    // SW x2,4(x1) with zero-wait memory: retires out of MEM
    fetchDecode("sw", 32'h0020_A223);
    execIdle("sw");
    nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    #1 expectCycle("sw_mem", 3'd3, 0, 0, 0, 1, 2'd0, 0, 2'd0, 1, 1, 0);
    retireCheck("sw", 32'd9);

    // Illegal opcode: trap and stay silent regardless of inputs
    fetchDecode("ill", 32'h0000_007F);
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      applyStimulus(1'b1, 32'h0050_0093, 1'b1, 1'b1);
      #1 expectCycle("trap_hold", 3'd5, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 1);
    end
    checkOutput("trap_instret", instret, 32'd9);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1 expectCycle("trap_reset", 3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    checkOutput("trap_reset_instret", instret, 32'd0);
    nextCycle();
    reset = 1'b0;

    // SW aborted by reset while waiting on data memory
    fetchDecode("swabort", 32'h0020_A223);
    execIdle("swabort");
    nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1 expectCycle("swabort_memwait", 3'd3, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 1, 0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    #1 expectCycle("swabort_reset", 3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    #1 expectCycle("swabort_after", 3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    checkOutput("swabort_instret", instret, 32'd0);
    nextCycle();
    #1 expectCycle("swabort_idle", 3'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);

    // Normal operation resumes after the abort
    fetchDecode("resume", 32'h0050_0093);
    execIdle("resume");
    wbCycle("resume", 1'b1, 2'd0, 2'd0);
    retireCheck("resume", 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It generates the enable that clocks the immediate generator, plus the PC, register-file and data-memory controls and an instruction-retired counter. It sits beside the decode stage and owns all sequencing; the datapath holds no state machine of its own.

## Interface
- No parameters; XLEN fixed at 32.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears state, opcode register and counter
- imem_ready  in  1  instruction word valid on `instr` this cycle
- instr  in  32  instruction word from instruction memory
- branch_taken  in  1  branch comparison result from ALU, valid in EXECUTE
- dmem_ready  in  1  data-memory access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_load  out  1  latch `instr` into IR (one-cycle pulse)
- imm_en  out  1  clock-enable for the immediate generator
- pc_we  out  1  PC write strobe
- pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result & ~1 (JALR)
- reg_we  out  1  register-file write strobe; never asserted when rd = 0
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm_u
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write (store)
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  current FSM state, for debug
- instret  out  32  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6–7 are unreachable and return to FETCH.
- Outputs are a Moore decode of `state` and the internally latched opcode (instr[6:0]), funct3 and rd. They are latched on `ir_load`.
- FETCH: imem_req=1. Stay while imem_ready=0. When imem_ready=1: ir_load=1, latch fields, go to DECODE.
- DECODE: imm_en=1.
  - Legal opcodes: 0000011, 0010011, 0110011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. These go to EXECUTE.
  - Any other opcode goes to TRAP.
- EXECUTE: ALU operands are valid because the immediate registered at the end of DECODE.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR → WB.
  - LOAD, STORE → MEM.
  - BRANCH: pc_we=1, pc_sel = branch_taken ? 1 : 0, retire, → FETCH.
- MEM: dmem_req=1; dmem_we=1 for STORE. Stay while dmem_ready=0.
  - On dmem_ready, LOAD → WB.
  - On dmem_ready, STORE: pc_we=1, pc_sel=0, retire, → FETCH.
- WB:
  - reg_we = (rd≠0).
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - pc_we=1; pc_sel: JAL=1, JALR=2, otherwise 0.
  - Retire, → FETCH.
- TRAP: illegal=1, all strobes 0. Held until reset.
- Retire: instret increments by 1 in the same cycle as the final pc_we. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - state=FETCH, so imem_req=1 immediately after reset.
  - All other strobes 0; pc_sel=0, wb_sel=0; illegal=0; instret=0; opcode register=0.
- Cycles with zero-wait memory (imem_ready and dmem_ready high):
  - ALU / LUI / AUIPC / JAL / JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle on imem_ready or dmem_ready adds exactly one cycle. Requests stay high and the latched fields stay stable while waiting.
- ir_load, pc_we and reg_we are single-cycle pulses per instruction. There is exactly one pc_we per retired instruction.
- Reset asserted mid-instruction aborts it. The state returns to FETCH with no pc_we, reg_we or dmem_req in the reset cycle or afterwards, and no retire.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.

## Structure
- A shared package `rv32_pkg` holds:
  - opcode constants (OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - state encodings;
  - PC_SEL_* and WB_SEL_* encodings.
  
  The immediate generator and ALU decode use the same package.
- Sub-module `op_class_dec`: combinational, opcode → {is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_alu, legal}. The FSM and instret counter live in the top module.

## Test plan
- ADDI x1,x0,5 (0x00500093) with ready always high → imm_en in cycle 2, WB in cycle 4 with reg_we=1, wb_sel=0, pc_we=1, pc_sel=0; instret 0→1.
- LW x2,0(x1) with dmem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1, dmem_we=0; then WB with wb_sel=1; total 8 cycles.
- BEQ taken, then the same BEQ not taken → EXECUTE pc_we with pc_sel=1, then pc_sel=0; reg_we never asserted; 3 cycles each.
- JALR x0,0(x1) → WB with reg_we=0 (rd=0), pc_sel=2; followed by ADDI x0,x0,0 → reg_we=0.
- Opcode 0x0000007F → TRAP in cycle 3; illegal=1 and no strobes for 20 cycles; reset → FETCH, illegal=0.
- Assert reset during the MEM wait of SW → no dmem_we after reset, instret unchanged, imem_req=1 next cycle.
